led_sequence_controller: RTL
============================

Name: led_sequence_controller

Overview:
Timed colour sequencer for the board's active-low RGB LED. It takes single-cycle run/step pulses, which upstream debounce and edge-detect logic produces from the buttons. It cycles RED -> GREEN -> BLUE on a programmable dwell period. It also supports idle, run and paused modes, and blinks the current colour while paused. It sits between the button conditioning chain and the LED pins and replaces hand-written colour FSMs in top-level modules.

Parameters:
DWELL_TICKS, 12_000_000, clk cycles each colour is held in RUN (1 s at 12 MHz); legal range >= 2
BLINK_TICKS, 3_000_000, clk cycles per blink half-period in PAUSED; legal range >= 1

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
run_pulse  input  1  one-cycle pulse: start / pause / resume
step_pulse  input  1  one-cycle pulse: advance colour manually
rgb  output  3  LED drive, active-low, {blue, green, red}
running  output  1  high while mode == RUN
color_idx  output  2  current colour: 0 = RED, 1 = GREEN, 2 = BLUE

Behaviour:
- Reset state: mode IDLE, color_idx 0, dwell_cnt 0, blink_cnt 0, blink_on 1, rgb 3'b111, running 0.
- Colour encodings: RED 3'b110, GREEN 3'b101, BLUE 3'b011, OFF 3'b111.
- Colour advance: 0 -> 1 -> 2 -> 0.
- Illegal color_idx 3: rgb drives 3'b000 (error indication). The next advance of any kind goes to 0.
- Mode FSM (registered; outputs are combinational from registered state, so they change 1 cycle after the causing pulse):
  - IDLE: rgb = OFF.
    - run_pulse -> RUN, dwell_cnt <= 0, colour unchanged.
    - step_pulse is ignored.
  - RUN: rgb = current colour; dwell_cnt increments every cycle.
    - When dwell_cnt == DWELL_TICKS-1: dwell_cnt <= 0 and colour advances.
    - step_pulse: colour advances, dwell_cnt <= 0.
    - run_pulse -> PAUSED with dwell_cnt held; blink_cnt <= 0, blink_on <= 1.
  - PAUSED: rgb = blink_on ? colour : OFF.
    - blink_cnt increments every cycle. At BLINK_TICKS-1: blink_cnt <= 0 and blink_on toggles.
    - step_pulse: colour advances, dwell_cnt <= 0, blink_cnt <= 0, blink_on <= 1.
    - run_pulse -> RUN, resuming from the held dwell_cnt.
- Priority: run_pulse beats step_pulse in the same cycle; step is dropped.
- Dwell expiry and step_pulse in the same RUN cycle produce exactly one advance; dwell_cnt <= 0.
- Counter widths: $clog2(DWELL_TICKS) and $clog2(BLINK_TICKS), minimum 1 bit. Counters never exceed TICKS-1.
- rst asserted in any mode, mid-count: everything returns to reset values on the next edge. rst beats all pulses.
- running == (mode == RUN). color_idx reflects the colour register in all modes.

Test Plan:
All scenarios use DWELL_TICKS=4, BLINK_TICKS=2.
- Reset, then 10 idle cycles -> rgb 3'b111, running 0, color_idx 0 throughout. Step_pulses during IDLE leave color_idx 0.
- run_pulse at cycle 0 -> running 1 and rgb 3'b110 from cycle 1. rgb becomes 3'b101 at cycle 5, 3'b011 at cycle 9, and 3'b110 at cycle 13 (wrap).
- In RUN at dwell_cnt 2, run_pulse -> rgb alternates on/off every 2 cycles, starting with on. A second run_pulse resumes RUN, and the colour advances 1 cycle after dwell_cnt reaches 3 (hold verified).
- step_pulse in RUN with dwell_cnt 3 (expiry cycle) -> color_idx advances by exactly 1 and dwell_cnt reads 0. run_pulse and step_pulse together in RUN -> mode PAUSED, colour unchanged.
- step_pulse in PAUSED while blink_on 0 -> colour advances, and rgb shows the new colour on the next cycle.
- rst asserted mid-RUN at color_idx 2 -> next cycle rgb 3'b111, running 0, color_idx 0. A concurrent run_pulse is ignored.

Source files
------------

// File: rtl/led_sequence_controller.sv
// Timed RED -> GREEN -> BLUE sequencer for an active-low RGB LED.
// Modes: IDLE (LED off), RUN (colour advances every DWELL_TICKS cycles),
// PAUSED (current colour blinks with a BLINK_TICKS half-period).
// Outputs are decoded from registered state, so they follow a pulse by one cycle.
module led_sequence_controller #(
    parameter int DWELL_TICKS = 12_000_000,
    parameter int BLINK_TICKS = 3_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_pulse,
    input  logic       step_pulse,
    output logic [2:0] rgb,
    output logic       running,
    output logic [1:0] color_idx
);

    localparam int DW = ($clog2(DWELL_TICKS) < 1) ? 1 : $clog2(DWELL_TICKS);
    localparam int BW = ($clog2(BLINK_TICKS) < 1) ? 1 : $clog2(BLINK_TICKS);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    // Active-low drive patterns, bit order {blue, green, red}
    localparam logic [2:0] RGB_RED   = 3'b110;
    localparam logic [2:0] RGB_GREEN = 3'b101;
    localparam logic [2:0] RGB_BLUE  = 3'b011;
    localparam logic [2:0] RGB_OFF   = 3'b111;
    localparam logic [2:0] RGB_ERR   = 3'b000;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_RUN    = 2'd1,
        MODE_PAUSED = 2'd2
    } mode_t;

    mode_t           mode_q, mode_d;
    logic [1:0]      color_q, color_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [BW-1:0]   blink_q, blink_d;
    logic            blink_on_q, blink_on_d;
    logic [1:0]      color_adv;
    logic [2:0]      color_rgb;

    // Next colour in the cycle; the illegal code 3 recovers to RED
    always_comb begin
        color_adv = 2'd0;
        case (color_q)
            2'd0:    color_adv = 2'd1;
            2'd1:    color_adv = 2'd2;
            default: color_adv = 2'd0;
        endcase
    end

    // Drive pattern for the current colour; code 3 lights everything as an error flag
    always_comb begin
        color_rgb = RGB_ERR;
        case (color_q)
            2'd0:    color_rgb = RGB_RED;
            2'd1:    color_rgb = RGB_GREEN;
            2'd2:    color_rgb = RGB_BLUE;
            default: color_rgb = RGB_ERR;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= MODE_IDLE;
            color_q    <= 2'd0;
            dwell_q    <= '0;
            blink_q    <= '0;
            blink_on_q <= 1'b1;
        end else begin
            mode_q     <= mode_d;
            color_q    <= color_d;
            dwell_q    <= dwell_d;
            blink_q    <= blink_d;
            blink_on_q <= blink_on_d;
        end
    end

    // Mode transitions and counter updates; run_pulse always wins over step_pulse
    always_comb begin
        mode_d     = mode_q;
        color_d    = color_q;
        dwell_d    = dwell_q;
        blink_d    = blink_q;
        blink_on_d = blink_on_q;
        case (mode_q)
            MODE_IDLE: begin
                if (run_pulse) begin
                    mode_d  = MODE_RUN;
                    dwell_d = '0;
                end
            end
            MODE_RUN: begin
                if (run_pulse) begin
                    // Dwell count is frozen so resume picks up where it left off
                    mode_d     = MODE_PAUSED;
                    blink_d    = '0;
                    blink_on_d = 1'b1;
                end else if (step_pulse || (dwell_q == DWELL_LAST)) begin
                    // Expiry and step coinciding still advance only once
                    color_d = color_adv;
                    dwell_d = '0;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            MODE_PAUSED: begin
                if (run_pulse) begin
                    mode_d = MODE_RUN;
                end else if (step_pulse) begin
                    // Restart the blink lit so the new colour is visible at once
                    color_d    = color_adv;
                    dwell_d    = '0;
                    blink_d    = '0;
                    blink_on_d = 1'b1;
                end else if (blink_q == BLINK_LAST) begin
                    blink_d    = '0;
                    blink_on_d = ~blink_on_q;
                end else begin
                    blink_d = blink_q + 1'b1;
                end
            end
            default: begin
                mode_d = MODE_IDLE;
            end
        endcase
    end

    // Output decode from registered state
    always_comb begin
        rgb = RGB_OFF;
        case (mode_q)
            MODE_RUN:    rgb = color_rgb;
            MODE_PAUSED: rgb = blink_on_q ? color_rgb : RGB_OFF;
            default:     rgb = RGB_OFF;
        endcase
    end

    assign running   = (mode_q == MODE_RUN);
    assign color_idx = color_q;

endmodule
